// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock behind a start/busy/done handshake.
// Optional overflow flag enabled by defining DIV_OVF_FLAG_EN.
module seq_divider #(
   parameter int unsigned DVD_W = 16,
   parameter int unsigned DVS_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [DVD_W-1:0] dividend,
   input  logic [DVS_W-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [DVD_W-1:0] quotient,
   output logic [DVS_W-1:0] remainder,
   output logic             dbz,
   output logic             ovf
);

   localparam int unsigned CNT_W = $clog2(DVD_W);
   localparam int unsigned PR_W  = DVS_W + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [DVD_W-1:0] shreg;
   logic [PR_W-1:0]  prem;
   logic [CNT_W-1:0] cnt;
   logic [DVS_W-1:0] dvs_q;

   logic [PR_W-1:0]  t_c;
   logic             ge_c;
   logic [PR_W-1:0]  prem_n;
   logic [DVD_W-1:0] shreg_n;
   logic             ovf_n;

   // The stored partial remainder never exceeds the divisor, so its top bit is never consumed.
   logic             unused_prem_msb;
   assign unused_prem_msb = prem[DVS_W];

   // One restoring iteration: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      t_c     = {prem[DVS_W-1:0], shreg[DVD_W-1]};
      ge_c    = (t_c >= PR_W'(dvs_q));
      prem_n  = ge_c ? (t_c - PR_W'(dvs_q)) : t_c;
      shreg_n = {shreg[DVD_W-2:0], ge_c};
`ifdef DIV_OVF_FLAG_EN
      ovf_n   = |shreg_n[DVD_W-1:DVS_W];
`else
      ovf_n   = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         dbz       <= 1'b0;
         ovf       <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         shreg     <= '0;
         prem      <= '0;
         cnt       <= '0;
         dvs_q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  busy <= 1'b1;
                  if (divisor != '0) begin
                     shreg <= dividend;
                     prem  <= '0;
                     cnt   <= '0;
                     dvs_q <= divisor;
                     state <= RUN;
                  end else begin
                     // Divide by zero short-circuits straight to a flagged result.
                     quotient  <= '1;
                     remainder <= dividend[DVS_W-1:0];
                     dbz       <= 1'b1;
                     ovf       <= 1'b0;
                     done      <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            RUN: begin
               shreg <= shreg_n;
               prem  <= prem_n;
               cnt   <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(DVD_W - 1)) begin
                  quotient  <= shreg_n;
                  remainder <= prem_n[DVS_W-1:0];
                  dbz       <= 1'b0;
                  ovf       <= ovf_n;
                  done      <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table plus hand-written
// sequences for ignored start and mid-run reset.
module tb_seq_divider;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic        busy;
   logic        done;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        dbz;
   logic        ovf;

`ifdef DIV_OVF_FLAG_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   seq_divider dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .dbz       (dbz),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] dvd;
      logic [7:0]  dvs;
      logic [15:0] q;
      logic [7:0]  r;
      logic        dbz;
      logic        ovf;
      int          lat;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issue one division at posedge+1 and check result, latency, busy and single-cycle done.
   task automatic run_div(input vec_t v);
      int n;
      bit busy_ok;
      dividend = v.dvd;
      divisor  = v.dvs;
      start    = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      dividend = 16'hA5A5;
      divisor  = 8'h00;
      n = 1;
      busy_ok = 1'b1;
      while (!done && n < 40) begin
         if (!busy) busy_ok = 1'b0;
         @(posedge clk); #1;
         n++;
      end
      if (!busy) busy_ok = 1'b0;
      check($sformatf("latency %0d/%0d", v.dvd, v.dvs), 32'(n), 32'(v.lat));
      check($sformatf("quotient %0d/%0d", v.dvd, v.dvs), 32'(quotient), 32'(v.q));
      check($sformatf("remainder %0d/%0d", v.dvd, v.dvs), 32'(remainder), 32'(v.r));
      check($sformatf("dbz %0d/%0d", v.dvd, v.dvs), 32'(dbz), 32'(v.dbz));
      check($sformatf("ovf %0d/%0d", v.dvd, v.dvs), 32'(ovf), 32'(v.ovf));
      check($sformatf("busy_span %0d/%0d", v.dvd, v.dvs), 32'(busy_ok), 32'd1);
      @(posedge clk); #1;
      check($sformatf("done_pulse %0d/%0d", v.dvd, v.dvs), 32'(done), 32'd0);
      check($sformatf("busy_drop %0d/%0d", v.dvd, v.dvs), 32'(busy), 32'd0);
   endtask

   initial begin
      int n;
      bit hold_ok;
      bit no_done;
      vec_t v;

      vecs[0] = '{16'd28600, 8'd200, 16'd143,   8'd0,   1'b0, 1'b0,   17};
      vecs[1] = '{16'd1000,  8'd7,   16'd142,   8'd6,   1'b0, 1'b0,   17};
      vecs[2] = '{16'd100,   8'd200, 16'd0,     8'd100, 1'b0, 1'b0,   17};
      vecs[3] = '{16'd0,     8'd1,   16'd0,     8'd0,   1'b0, 1'b0,   17};
      vecs[4] = '{16'd65535, 8'd255, 16'd257,   8'd0,   1'b0, OVF_ON, 17};
      vecs[5] = '{16'd65025, 8'd255, 16'd255,   8'd0,   1'b0, 1'b0,   17};
      vecs[6] = '{16'd1234,  8'd0,   16'hFFFF,  8'hD2,  1'b1, 1'b0,   1};
      vecs[7] = '{16'd1000,  8'd7,   16'd142,   8'd6,   1'b0, 1'b0,   17};

      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset quotient", 32'(quotient), 32'd0);
      check("reset remainder", 32'(remainder), 32'd0);
      check("reset dbz", 32'(dbz), 32'd0);
      check("reset ovf", 32'(ovf), 32'd0);

      for (int i = 0; i < 8; i++) run_div(vecs[i]);

      // Establish a distinct previous result, then a start pulse mid-run must be ignored.
      v = '{16'd100, 8'd200, 16'd0, 8'd100, 1'b0, 1'b0, 17};
      run_div(v);
      dividend = 16'd1000;
      divisor  = 8'd7;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 1;
      hold_ok = 1'b1;
      while (!done && n < 40) begin
         if (n == 8) begin
            dividend = 16'd5000;
            divisor  = 8'd3;
            start    = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (quotient !== 16'd0 || remainder !== 8'd100) hold_ok = 1'b0;
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      check("ignored latency", 32'(n), 32'd17);
      check("ignored quotient", 32'(quotient), 32'd142);
      check("ignored remainder", 32'(remainder), 32'd6);
      check("ignored hold", 32'(hold_ok), 32'd1);
      no_done = 1'b1;
      repeat (20) begin
         @(posedge clk); #1;
         if (done) no_done = 1'b0;
      end
      check("ignored no_requeue", 32'(no_done), 32'd1);

      // Reset for one cycle in the middle of a run aborts it.
      dividend = 16'd1000;
      divisor  = 8'd7;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort quotient", 32'(quotient), 32'd0);
      check("abort remainder", 32'(remainder), 32'd0);
      check("abort dbz", 32'(dbz), 32'd0);
      no_done = 1'b1;
      repeat (20) begin
         @(posedge clk); #1;
         if (done || busy) no_done = 1'b0;
      end
      check("abort quiet", 32'(no_done), 32'd1);
      v = '{16'd255, 8'd16, 16'd15, 8'd15, 1'b0, 1'b0, 17};
      run_div(v);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
